// File: rtl/simon_sequence_player.sv
// Simon sequence player: rewinds the LFSR, pulls two bits per colour (MSB
// first) and shows each of the first `length` colours for ON_CYCLES clocks,
// followed by OFF_CYCLES dark clocks. Outputs are Moore-decoded from state.
module simon_sequence_player #(
  parameter int unsigned ON_CYCLES  = 12_000_000,
  parameter int unsigned OFF_CYCLES = 6_000_000,
  parameter int unsigned TW         = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] length,
  input  logic       random,
  output logic       lfsr_step,
  output logic       lfsr_rerun,
  output logic [1:0] color,
  output logic       led_enable,
  output logic       busy,
  output logic       done,
  output logic [7:0] index
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RERUN,
    S_FETCH_HI,
    S_FETCH_LO,
    S_ON,
    S_OFF,
    S_DONE
  } state_e;

  localparam logic [TW-1:0] ON_LAST  = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0] OFF_LAST = TW'(OFF_CYCLES - 1);

  state_e          state_q, state_d;
  logic [7:0]      len_q, len_d;
  logic [7:0]      index_q, index_d;
  logic [7:0]      index_inc;
  logic [1:0]      color_q, color_d;
  logic [TW-1:0]   timer_q, timer_d;

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      index_q <= '0;
      color_q <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      index_q <= index_d;
      color_q <= color_d;
      timer_q <= timer_d;
    end
  end

  // Next-state logic; abort overrides every non-idle transition.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    index_d   = index_q;
    color_d   = color_q;
    timer_d   = timer_q;
    index_inc = index_q + 8'd1;

    unique case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          index_d = '0;
          if (length != 8'd0) begin
            len_d   = length;
            state_d = S_RERUN;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_RERUN: state_d = S_FETCH_HI;
      S_FETCH_HI: begin
        color_d[1] = random;
        state_d    = S_FETCH_LO;
      end
      S_FETCH_LO: begin
        color_d[0] = random;
        timer_d    = '0;
        state_d    = S_ON;
      end
      S_ON: begin
        if (timer_q == ON_LAST) begin
          timer_d = '0;
          state_d = S_OFF;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_OFF: begin
        if (timer_q == OFF_LAST) begin
          timer_d = '0;
          index_d = index_inc;
          state_d = (index_inc == len_q) ? S_DONE : S_FETCH_HI;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      index_d = index_q;
      color_d = color_q;
      timer_d = '0;
    end
  end

  // Moore output decode.
  always_comb begin
    lfsr_step  = (state_q == S_FETCH_HI) || (state_q == S_FETCH_LO);
    lfsr_rerun = (state_q == S_RERUN);
    led_enable = (state_q == S_ON);
    busy       = (state_q != S_IDLE);
    done       = (state_q == S_DONE);
    color      = color_q;
    index      = index_q;
  end

endmodule
